// File: rtl/return_stack_if.sv
// Control-unit / PC side bundle for the return-address stack.
// The control unit drives push/pop/err_clr. The stack drives the PC load path and status.
interface return_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] pc_data;
  logic             pc_write;
  logic [WIDTH-1:0] top;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_data, pop, err_clr,
    input  pc_data, pc_write, top, count, empty, full, overflow, underflow
  );
  modport slave (
    input  push, push_data, pop, err_clr,
    output pc_data, pc_write, top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Circular return-address stack feeding the PC write port.
// A pop produces a registered one-cycle pc_write strobe together with the popped address.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  return_stack_if.slave s
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp, tp;
  logic [AW:0]      count;
  logic             nonempty, is_full, do_pop, replace, ovf_set, unf_set;

  assign tp       = sp - 1'b1;
  assign nonempty = (count != '0);
  assign is_full  = (count == FULL_CNT);
  assign do_pop   = s.pop && nonempty;
  assign replace  = s.push && do_pop;
  // Overflow only flags a push that actually evicts the oldest entry.
  assign ovf_set  = s.push && !s.pop && is_full;
  assign unf_set  = s.pop && !nonempty;

  // Storage has no reset; reset still blocks writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (replace)     mem[tp] <= s.push_data;
      else if (s.push) mem[sp] <= s.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp          <= '0;
      count       <= '0;
      s.pc_data   <= '0;
      s.pc_write  <= 1'b0;
      s.overflow  <= 1'b0;
      s.underflow <= 1'b0;
    end else begin
      s.pc_write <= do_pop;
      if (do_pop) s.pc_data <= mem[tp];

      if (!replace) begin
        if (s.push) begin
          sp <= sp + 1'b1;
          if (!is_full) count <= count + 1'b1;
        end else if (do_pop) begin
          sp    <= tp;
          count <= count - 1'b1;
        end
      end

      s.overflow  <= ovf_set || (s.overflow  && !s.err_clr);
      s.underflow <= unf_set || (s.underflow && !s.err_clr);
    end
  end

  assign s.count = count;
  assign s.empty = !nonempty;
  assign s.full  = is_full;
  assign s.top   = nonempty ? mem[tp] : '0;
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack that supplies the PC write path: on a call it captures the PC+1 value, and on a return it drives the PC load data and write strobe.
- Sits between the program-counter register and the control unit.
- The control unit asserts push on CALL-class instructions and pop on RET.
- The stack drives the PC's data/write inputs one cycle later (registered).
- Circular storage; oldest entry is overwritten on overflow.

Parameters:
- WIDTH, 16, address/data width (matches PC width).
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- AW, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-low.
- push  input  1  store push_data as new top this cycle.
- push_data  input  WIDTH  return address (PC+1 from the program counter).
- pop  input  1  remove top entry and send it to the PC.
- err_clr  input  1  clear sticky overflow/underflow flags.
- pc_data  output  WIDTH  registered popped address, to PC data input.
- pc_write  output  1  registered one-cycle strobe, to PC write input.
- top  output  WIDTH  current top entry (combinational from storage); 0 when empty.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- State: storage array mem[DEPTH], pointer sp (AW bits, index of next free slot), count.
- Top index is sp-1, modulo DEPTH.
- Reset (rst==0 at posedge):
  - sp=0, count=0, pc_data=0, pc_write=0, overflow=0, underflow=0.
  - mem contents are don't-care; top reads 0 because the stack is empty.
  - Reset wins over all other inputs, including mid-sequence push/pop.
- Push only (push=1, pop=0):
  - mem[sp]<=push_data; sp<=sp+1 (wraps modulo DEPTH).
  - count<=count+1, saturating at DEPTH.
  - If full: the oldest entry is overwritten (circular); count stays DEPTH; overflow<=1.
  - The new top is visible on top the next cycle.
- Pop only (push=0, pop=1):
  - If count>0: pc_data<=mem[sp-1]; pc_write<=1 next cycle; sp<=sp-1; count<=count-1.
  - If empty: no pointer change; pc_write stays 0; pc_data holds; underflow<=1.
- Push and pop together:
  - If count>0: pc_data<=old top; pc_write<=1; mem[sp-1]<=push_data; sp and count unchanged (top replaced).
  - If empty: underflow<=1; no pc_write; push proceeds normally (count becomes 1).
- Neither push nor pop: pc_write<=0; pc_data holds its last value.
- Latency: pop sampled at edge N gives pc_write=1 and pc_data valid during cycle N..N+1. The strobe is exactly one cycle wide per accepted pop; back-to-back pops give back-to-back strobes.
- Sticky flags:
  - err_clr=1 clears both flags.
  - If the same cycle sets a flag, set wins.
- empty, full and top are derived combinationally from count/sp/mem; there are no extra register stages.
- Arithmetic: sp uses modulo-DEPTH wrap with no bounds error; count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset: hold rst=0 two cycles with push=1 -> count=0, empty=1, top=0, pc_write=0, pc_data=0, both flags 0.
- LIFO order:
  - Push 0x0011, 0x0022, 0x0033 on consecutive cycles -> count=3, top=0x0033.
  - Then pop three times -> pc_write pulses on three consecutive cycles with pc_data=0x0033, 0x0022, 0x0011.
  - Ends with empty=1.
- Overflow (DEPTH=8):
  - Push 0x0100..0x0108 (9 pushes) -> full=1, count=8, overflow=1.
  - Eight pops return 0x0108 down to 0x0101; 0x0100 is lost.
- Underflow: pop while empty -> pc_write stays 0, pc_data unchanged, underflow=1; err_clr=1 for one cycle -> underflow=0.
- Simultaneous push/pop:
  - With stack [0x0AAA,0x0BBB] (top 0x0BBB), assert push=1 push_data=0x0CCC and pop=1 -> pc_write=1, pc_data=0x0BBB, count=2, top=0x0CCC.
  - On empty, the same stimulus gives underflow=1, count=1, top=0x0CCC.
- Reset mid-operation: push 3 entries, then assert rst=0 in the same cycle as pop=1 -> next cycle pc_write=0, count=0, empty=1.
